// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage RV32I core.
// Keeps a single request outstanding to a variable-latency instruction memory.
module fetch_stage #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter logic [31:0]       NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] PCF,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pcF_q, pcF_d;
    logic            discard_q, discard_d;
    logic [31:0]     holdInstr_q, holdInstr_d;
    logic [31:0]     instrD_q, instrD_d;
    logic [XLEN-1:0] pcD_q, pcD_d;
    logic [XLEN-1:0] pcPlus4D_q, pcPlus4D_d;
    logic            validD_q, validD_d;

    logic            load;
    logic [31:0]     loadInstr;
    logic [XLEN-1:0] pcPlus4;

    assign pcPlus4   = pcF_q + XLEN'(32'd4);
    assign imem_req  = reset & (state_q == S_ISSUE) & ~stallF & ~PCSrcE;
    assign imem_addr = pcF_q;
    assign PCF       = pcF_q;
    assign InstrD    = instrD_q;
    assign PCD       = pcD_q;
    assign PCPlus4D  = pcPlus4D_q;
    assign ValidD    = validD_q;

    always_comb begin
        state_d     = state_q;
        pcF_d       = pcF_q;
        discard_d   = discard_q;
        holdInstr_d = holdInstr_q;
        load        = 1'b0;
        loadInstr   = imem_rdata;

        case (state_q)
            S_ISSUE: begin
                if (PCSrcE) begin
                    pcF_d = PCTargetE;
                end else if (!stallF) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (PCSrcE) begin
                        pcF_d     = PCTargetE;
                        discard_d = 1'b0;
                        state_d   = S_ISSUE;
                    end else if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_ISSUE;
                    end else if (!stallD) begin
                        load    = 1'b1;
                        pcF_d   = pcPlus4;
                        state_d = S_ISSUE;
                    end else begin
                        holdInstr_d = imem_rdata;
                        state_d     = S_HOLD;
                    end
                end else if (PCSrcE) begin
                    // Redirect while the old fetch is still in flight: its response must be dropped
                    discard_d = 1'b1;
                    pcF_d     = PCTargetE;
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    pcF_d   = PCTargetE;
                    state_d = S_ISSUE;
                end else if (!stallD) begin
                    load      = 1'b1;
                    loadInstr = holdInstr_q;
                    pcF_d     = pcPlus4;
                    state_d   = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE;
        endcase

        instrD_d   = instrD_q;
        pcD_d      = pcD_q;
        pcPlus4D_d = pcPlus4D_q;
        validD_d   = validD_q;
        if (flushD) begin
            instrD_d = NOP;
            validD_d = 1'b0;
        end else if (!stallD) begin
            if (load) begin
                instrD_d   = loadInstr;
                pcD_d      = pcF_q;
                pcPlus4D_d = pcPlus4;
                validD_d   = 1'b1;
            end else begin
                instrD_d = NOP;
                validD_d = 1'b0;
            end
        end
    end

    // A reset landing during WAIT leaves one response in flight; remember to drop it
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_ISSUE;
            pcF_q       <= RESET_PC;
            discard_q   <= (state_q == S_WAIT);
            holdInstr_q <= '0;
            instrD_q    <= NOP;
            pcD_q       <= '0;
            pcPlus4D_q  <= '0;
            validD_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcF_q       <= pcF_d;
            discard_q   <= discard_d;
            holdInstr_q <= holdInstr_d;
            instrD_q    <= instrD_d;
            pcD_q       <= pcD_d;
            pcPlus4D_q  <= pcPlus4D_d;
            validD_q    <= validD_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: randomized hazards and memory latency
// checked against a transaction-level model of the expected instruction stream.
module tb_fetch_stage;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stallF, stallD, flushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;

    logic        reset2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_rvalid2;
    logic [31:0] imem_rdata2;
    logic [31:0] PCF2, InstrD2, PCD2, PCPlus4D2;
    logic        ValidD2;

    int          checks;
    int          failures;

    // Model state: expected next PC to deliver, memory outstanding request, held response
    logic [31:0] expPC;
    bit          pending;
    bit          stale;
    bit          held;
    int          dueCyc;
    int          cyc;
    int          memLat;
    int          deliveries;
    logic [31:0] pendData;
    logic [31:0] staleData;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP(NOP_W)) dut (
        .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PCF(PCF), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP(NOP_W)) dutWrap (
        .clk(clk), .reset(reset2), .stallF(1'b0), .stallD(1'b0), .flushD(1'b0),
        .PCSrcE(1'b0), .PCTargetE(32'h0), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2), .PCF(PCF2), .InstrD(InstrD2),
        .PCD(PCD2), .PCPlus4D(PCPlus4D2), .ValidD(ValidD2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h0050_0093;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check request side, then check IF/ID after the edge
    task automatic applyStimulus(input logic sF, input logic sD, input logic fD,
                                 input logic br, input logic [31:0] tgt);
        logic        rv, reqNow, arrivedFresh, avail, deliver, prevValid;
        logic [31:0] addrNow, prevInstr, prevPcd, prevP4;
        stallF    = sF;
        stallD    = sD;
        flushD    = fD;
        PCSrcE    = br;
        PCTargetE = tgt;
        rv = pending && (cyc >= dueCyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? pendData : $urandom;
        #1;
        checkOutput("pcf", PCF, expPC);
        if (sF || br) checkOutput("req_gate", 32'(imem_req), 32'd0);
        reqNow  = imem_req;
        addrNow = imem_addr;
        if (reqNow) begin
            checkOutput("req_single", 32'(pending), 32'd0);
            checkOutput("req_addr", addrNow, expPC);
        end
        prevInstr = InstrD;
        prevPcd   = PCD;
        prevP4    = PCPlus4D;
        prevValid = ValidD;
        @(posedge clk);
        #1;
        arrivedFresh = rv && !stale;
        if (rv) begin
            pending = 0;
            stale   = 0;
        end
        if (br && pending) stale = 1;
        if (reqNow) begin
            pending  = 1;
            stale    = 0;
            dueCyc   = cyc + memLat;
            pendData = memWord(addrNow);
        end
        avail   = held || arrivedFresh;
        deliver = 1'b0;
        if (br) held = 0;
        else if (sD) held = avail;
        else begin
            deliver = avail;
            held    = 0;
        end
        if (fD) begin
            checkOutput("flush_valid", 32'(ValidD), 32'd0);
            checkOutput("flush_instr", InstrD, NOP_W);
            checkOutput("flush_pcd", PCD, prevPcd);
            checkOutput("flush_pcp4", PCPlus4D, prevP4);
        end else if (sD) begin
            checkOutput("stall_valid", 32'(ValidD), 32'(prevValid));
            checkOutput("stall_instr", InstrD, prevInstr);
            checkOutput("stall_pcd", PCD, prevPcd);
            checkOutput("stall_pcp4", PCPlus4D, prevP4);
        end else begin
            checkOutput("validD", 32'(ValidD), 32'(deliver));
            if (deliver) begin
                checkOutput("deliver_pcd", PCD, expPC);
                checkOutput("deliver_instr", InstrD, memWord(expPC));
                checkOutput("deliver_pcp4", PCPlus4D, expPC + 32'd4);
                expPC = expPC + 32'd4;
                deliveries++;
            end else begin
                checkOutput("bubble_instr", InstrD, NOP_W);
            end
        end
        if (br) expPC = tgt;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic sDr, brr, fDr;
        int   guard;
        clk = 0; reset = 0; reset2 = 0;
        stallF = 0; stallD = 0; flushD = 0; PCSrcE = 0; PCTargetE = 0;
        imem_rvalid = 0; imem_rdata = 0; imem_rvalid2 = 0; imem_rdata2 = 0;
        checks = 0; failures = 0; cyc = 0; memLat = 1; deliveries = 0;
        pending = 0; stale = 0; held = 0; dueCyc = 0; pendData = 0;
        expPC = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_pcf", PCF, 32'h0);
        checkOutput("rst_instr", InstrD, NOP_W);
        checkOutput("rst_pcd", PCD, 32'h0);
        checkOutput("rst_pcp4", PCPlus4D, 32'h0);
        checkOutput("rst_valid", 32'(ValidD), 32'd0);
        reset = 1;

        $display("[TB] directed: zero-wait stream, stall into HOLD, redirects, flush vs stall");
        repeat (5) applyStimulus(0, 0, 0, 0, 32'h0);
        repeat (3) applyStimulus(1, 1, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("hold_release_pcd", PCD, 32'h8);
        memLat = 3;
        applyStimulus(0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 1, 1, 32'h100);
        applyStimulus(0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        memLat = 1;
        applyStimulus(0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("redirect_pcd", PCD, 32'h100);
        memLat = 2;
        applyStimulus(0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 1, 1, 32'h200);
        memLat = 1;
        applyStimulus(0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);

        $display("[TB] random hazards and memory latency");
        for (int i = 0; i < 600; i++) begin
            memLat = $urandom_range(1, 4);
            sDr = ($urandom_range(0, 4) == 0);
            brr = ($urandom_range(0, 9) == 0);
            fDr = brr | (sDr & ($urandom_range(0, 3) == 0));
            applyStimulus(sDr, sDr, fDr, brr,
                          ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC));
        end
        checkOutput("progress", 32'(deliveries >= 20), 32'd1);

        $display("[TB] reset during WAIT with a late response");
        memLat = 6;
        guard = 0;
        while (!(pending && dueCyc > cyc + 2) && guard < 40) begin
            applyStimulus(0, 0, 0, 0, 32'h0);
            guard++;
        end
        checkOutput("wait_timeout", 32'(guard < 40), 32'd1);
        staleData = pendData;
        reset = 0;
        imem_rvalid = 0;
        #1;
        checkOutput("rst2_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst2_pcf", PCF, 32'h0);
        checkOutput("rst2_instr", InstrD, NOP_W);
        checkOutput("rst2_pcd", PCD, 32'h0);
        checkOutput("rst2_pcp4", PCPlus4D, 32'h0);
        checkOutput("rst2_valid", 32'(ValidD), 32'd0);
        @(negedge clk);
        reset = 1;
        #1;
        checkOutput("post_rst_req", 32'(imem_req), 32'd1);
        checkOutput("post_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_rvalid = 1;
        imem_rdata  = staleData;
        @(posedge clk);
        #1;
        checkOutput("rst_stale_drop", 32'(ValidD), 32'd0);
        checkOutput("rst_stale_instr", InstrD, NOP_W);
        @(negedge clk);
        imem_rdata = memWord(32'h0);
        #1;
        checkOutput("reissue_req", 32'(imem_req), 32'd1);
        checkOutput("reissue_addr", imem_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        imem_rvalid = 0;
        pending = 1; stale = 0; held = 0; dueCyc = cyc; pendData = memWord(32'h0);
        expPC = 32'h0; memLat = 1;
        repeat (6) applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("post_rst_deliveries", PCD, 32'h8);

        $display("[TB] PC wrap from RESET_PC=FFFFFFFC");
        reset2 = 1;
        imem_rvalid2 = 0;
        #1;
        checkOutput("wrap_req0", 32'(imem_req2), 32'd1);
        checkOutput("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        imem_rvalid2 = 1;
        imem_rdata2  = memWord(32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        checkOutput("wrap_valid", 32'(ValidD2), 32'd1);
        checkOutput("wrap_pcd", PCD2, 32'hFFFF_FFFC);
        checkOutput("wrap_pcp4", PCPlus4D2, 32'h0);
        checkOutput("wrap_instr", InstrD2, memWord(32'hFFFF_FFFC));
        @(negedge clk);
        imem_rvalid2 = 0;
        #1;
        checkOutput("wrap_req1", 32'(imem_req2), 32'd1);
        checkOutput("wrap_addr1", imem_addr2, 32'h0);
        checkOutput("wrap_pcf", PCF2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
